// File: rtl/fetch_unit.sv
// Instruction fetch stage for the Light RV32I core: owns the PC, runs a single
// outstanding req/ack fetch, holds the instruction through EXEC, then redirects.
`ifndef _INST_WIDTH_
`define _INST_WIDTH_ 32
`endif

module fetch_unit #(
    parameter int                    INST_WIDTH = `_INST_WIDTH_,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_n,
    output logic                  o_ImemReq,
    output logic [ADDR_WIDTH-1:0] o_ImemAddr,
    input  logic                  i_ImemAck,
    input  logic [INST_WIDTH-1:0] i_ImemRdata,
    output logic [INST_WIDTH-1:0] o_Instruction,
    output logic [ADDR_WIDTH-1:0] o_Pc,
    output logic                  o_InstValid,
    input  logic                  i_Stall,
    input  logic                  i_Branch,
    input  logic                  i_Zero,
    input  logic                  i_Jump,
    input  logic [ADDR_WIDTH-1:0] i_Target,
    output logic                  o_Fault,
    output logic [31:0]           o_RetireCnt
);

    localparam logic [INST_WIDTH-1:0] NOP = INST_WIDTH'(32'h0000_0013);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_FAULT
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic [ADDR_WIDTH-1:0] next_pc;
    logic                  taken;
    logic                  misaligned;

    // Redirect decision is only consumed on the EXEC exit cycle.
    assign pc_plus4   = pc + ADDR_WIDTH'(4);
    assign taken      = i_Jump | (i_Branch & i_Zero);
    assign next_pc    = taken ? i_Target : pc_plus4;
    assign misaligned = taken & (i_Target[1:0] != 2'b00);
    assign o_ImemAddr = pc;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state         <= S_IDLE;
            pc            <= RESET_PC;
            o_ImemReq     <= 1'b0;
            o_Instruction <= NOP;
            o_Pc          <= RESET_PC;
            o_InstValid   <= 1'b0;
            o_Fault       <= 1'b0;
            o_RetireCnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state     <= S_FETCH;
                    o_ImemReq <= 1'b1;
                end
                S_FETCH: begin
                    if (i_ImemAck) begin
                        o_Instruction <= i_ImemRdata;
                        o_Pc          <= pc;
                        o_ImemReq     <= 1'b0;
                        o_InstValid   <= 1'b1;
                        state         <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (!i_Stall) begin
                        o_InstValid <= 1'b0;
                        if (misaligned) begin
                            // PC and retire count stay on the faulting instruction.
                            o_Fault <= 1'b1;
                            state   <= S_FAULT;
                        end else begin
                            pc          <= next_pc;
                            o_RetireCnt <= o_RetireCnt + 32'd1;
                            o_ImemReq   <= 1'b1;
                            state       <= S_FETCH;
                        end
                    end
                end
                S_FAULT: begin
                    o_Fault     <= 1'b1;
                    o_ImemReq   <= 1'b0;
                    o_InstValid <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: handshake timing, redirects, stall, wrap,
// misaligned-target fault and asynchronous reset.
module tb_fetch_unit;

    logic        i_Clk = 1'b0;
    logic        i_Rst_n;
    logic        o_ImemReq;
    logic [31:0] o_ImemAddr;
    logic        i_ImemAck;
    logic [31:0] i_ImemRdata;
    logic [31:0] o_Instruction;
    logic [31:0] o_Pc;
    logic        o_InstValid;
    logic        i_Stall;
    logic        i_Branch;
    logic        i_Zero;
    logic        i_Jump;
    logic [31:0] i_Target;
    logic        o_Fault;
    logic [31:0] o_RetireCnt;

    int n_chk  = 0;
    int n_fail = 0;

    fetch_unit dut (
        .i_Clk        (i_Clk),
        .i_Rst_n      (i_Rst_n),
        .o_ImemReq    (o_ImemReq),
        .o_ImemAddr   (o_ImemAddr),
        .i_ImemAck    (i_ImemAck),
        .i_ImemRdata  (i_ImemRdata),
        .o_Instruction(o_Instruction),
        .o_Pc         (o_Pc),
        .o_InstValid  (o_InstValid),
        .i_Stall      (i_Stall),
        .i_Branch     (i_Branch),
        .i_Zero       (i_Zero),
        .i_Jump       (i_Jump),
        .i_Target     (i_Target),
        .o_Fault      (o_Fault),
        .o_RetireCnt  (o_RetireCnt)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge i_Clk);
        @(negedge i_Clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"},   o_ImemReq,     0);
        chk({tag, "_addr"},  o_ImemAddr,    0);
        chk({tag, "_pc"},    o_Pc,          0);
        chk({tag, "_inst"},  o_Instruction, 32'h0000_0013);
        chk({tag, "_valid"}, o_InstValid,   0);
        chk({tag, "_fault"}, o_Fault,       0);
        chk({tag, "_cnt"},   o_RetireCnt,   0);
    endtask

    // Entered at a negedge with the DUT in FETCH; leaves at the negedge in EXEC.
    task automatic do_fetch(input int wait_n, input logic [31:0] data, input logic [31:0] addr);
        for (int i = 0; i < wait_n; i++) begin
            chk("wait_req",   o_ImemReq,   1);
            chk("wait_addr",  o_ImemAddr,  addr);
            chk("wait_valid", o_InstValid, 0);
            step();
        end
        chk("fetch_req",  o_ImemReq,  1);
        chk("fetch_addr", o_ImemAddr, addr);
        i_ImemAck   = 1'b1;
        i_ImemRdata = data;
        step();
        i_ImemAck   = 1'b0;
        i_ImemRdata = 32'hDEAD_BEEF;
        chk("exec_valid", o_InstValid,   1);
        chk("exec_inst",  o_Instruction, data);
        chk("exec_pc",    o_Pc,          addr);
        chk("exec_req",   o_ImemReq,     0);
    endtask

    task automatic exec_exit(input logic br, input logic z, input logic j, input logic [31:0] tgt);
        i_Stall  = 1'b0;
        i_Branch = br;
        i_Zero   = z;
        i_Jump   = j;
        i_Target = tgt;
        step();
        i_Branch = 1'b0;
        i_Zero   = 1'b0;
        i_Jump   = 1'b0;
        i_Target = 32'h0000_0003;
    endtask

    task automatic chk_next(input string tag, input logic [31:0] addr, input logic [31:0] cnt);
        chk({tag, "_req"},   o_ImemReq,   1);
        chk({tag, "_addr"},  o_ImemAddr,  addr);
        chk({tag, "_valid"}, o_InstValid, 0);
        chk({tag, "_cnt"},   o_RetireCnt, cnt);
    endtask

    task automatic release_reset;
        i_Rst_n = 1'b1;
        chk("idle_req", o_ImemReq, 0);
        step();
    endtask

    initial begin
        i_Rst_n     = 1'b0;
        i_ImemAck   = 1'b0;
        i_ImemRdata = 32'h0;
        i_Stall     = 1'b0;
        i_Branch    = 1'b0;
        i_Zero      = 1'b0;
        i_Jump      = 1'b0;
        i_Target    = 32'h0;
        repeat (2) @(negedge i_Clk);
        chk_reset_vals("rst");

        release_reset();
        do_fetch(0, 32'h0050_0093, 32'h0);
        exec_exit(0, 0, 0, 32'h0);
        chk_next("seq4", 32'h4, 1);

        do_fetch(0, 32'h0010_0113, 32'h4);
        exec_exit(0, 0, 0, 32'h0);
        chk_next("seq8", 32'h8, 2);

        do_fetch(3, 32'h0020_8193, 32'h8);
        exec_exit(1, 1, 0, 32'h40);
        chk_next("br_taken", 32'h40, 3);

        do_fetch(0, 32'h0000_0463, 32'h40);
        exec_exit(1, 0, 0, 32'h81);
        chk_next("br_not_taken", 32'h44, 4);

        // Stall with a stray ack that must be ignored outside FETCH.
        do_fetch(0, 32'h1234_5013, 32'h44);
        i_Stall     = 1'b1;
        i_ImemAck   = 1'b1;
        i_ImemRdata = 32'hFFFF_FFFF;
        i_Jump      = 1'b1;
        i_Target    = 32'h2;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_valid", o_InstValid,   1);
            chk("stall_inst",  o_Instruction, 32'h1234_5013);
            chk("stall_pc",    o_Pc,          32'h44);
            chk("stall_req",   o_ImemReq,     0);
            chk("stall_cnt",   o_RetireCnt,   4);
            chk("stall_fault", o_Fault,       0);
        end
        i_ImemAck = 1'b0;
        exec_exit(0, 0, 0, 32'h0);
        chk_next("stall_exit", 32'h48, 5);

        do_fetch(0, 32'h0000_006F, 32'h48);
        exec_exit(0, 0, 1, 32'hFFFF_FFFC);
        chk_next("jmp_top", 32'hFFFF_FFFC, 6);
        do_fetch(0, 32'h0000_0013, 32'hFFFF_FFFC);
        exec_exit(0, 0, 0, 32'h0);
        chk_next("pc_wrap", 32'h0, 7);
        do_fetch(0, 32'h1000_006F, 32'h0);
        exec_exit(0, 0, 1, 32'h100);
        chk_next("jmp_100", 32'h100, 8);

        // Abandon a pending request with an async reset between clock edges.
        step();
        chk("pend_req", o_ImemReq, 1);
        #1 i_Rst_n = 1'b0;
        #1 chk_reset_vals("async_rst");
        @(negedge i_Clk);
        chk_reset_vals("async_rst_hold");

        release_reset();
        do_fetch(0, 32'h0050_0093, 32'h0);
        exec_exit(0, 0, 0, 32'h0);
        chk_next("post_rst", 32'h4, 1);
        do_fetch(0, 32'h0220_006F, 32'h4);
        exec_exit(0, 0, 1, 32'h22);
        for (int i = 0; i < 3; i++) begin
            i_ImemAck = 1'b1;
            chk("fault_flag",  o_Fault,     1);
            chk("fault_req",   o_ImemReq,   0);
            chk("fault_valid", o_InstValid, 0);
            chk("fault_cnt",   o_RetireCnt, 1);
            chk("fault_addr",  o_ImemAddr,  32'h4);
            step();
        end
        i_ImemAck = 1'b0;
        i_Rst_n   = 1'b0;
        #1 chk_reset_vals("fault_clr");
        @(negedge i_Clk);
        release_reset();
        chk_next("refetch", 32'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the single-cycle-decode Light RV32I core. It owns the program counter and issues one instruction-memory request at a time over a request/acknowledge handshake. It holds the returned word stable on `o_Instruction` for the decode controller and datapath, then advances the PC to PC+4 or to the branch/jump target reported back by the datapath. It also flags misaligned control-flow targets and counts retired instructions.

## Interface
- `INST_WIDTH`, default `` `_INST_WIDTH_ `` (32): instruction word width.
- `ADDR_WIDTH`, default 32: PC / instruction address width.
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `i_Clk`  in  1  clock; all state changes on the rising edge.
- `i_Rst_n`  in  1  reset; asynchronous, active-low.
- `o_ImemReq`  out  1  fetch request; held high until acknowledged.
- `o_ImemAddr`  out  ADDR_WIDTH  fetch address; always equals the current PC.
- `i_ImemAck`  in  1  memory accepts the request; data is valid in the same cycle.
- `i_ImemRdata`  in  INST_WIDTH  instruction word; sampled only when `o_ImemReq & i_ImemAck`.
- `o_Instruction`  out  INST_WIDTH  latched instruction, fed to the decode controller.
- `o_Pc`  out  ADDR_WIDTH  PC of `o_Instruction`.
- `o_InstValid`  out  1  high while in EXEC; `o_Instruction`/`o_Pc` are meaningful only then.
- `i_Stall`  in  1  datapath hold; keeps the fetch unit in EXEC.
- `i_Branch`  in  1  decoded conditional branch (BEQ).
- `i_Zero`  in  1  ALU zero flag; branch is taken when both `i_Branch` and `i_Zero` are high.
- `i_Jump`  in  1  decoded unconditional jump.
- `i_Target`  in  ADDR_WIDTH  branch/jump target computed by the datapath.
- `o_Fault`  out  1  sticky misaligned-target fault.
- `o_RetireCnt`  out  32  count of instructions that have left EXEC.

## Operation
- States: IDLE, FETCH, EXEC, FAULT. Reset state is IDLE.
- IDLE → FETCH unconditionally, one cycle after reset release.
- FETCH:
  - `o_ImemReq`=1 and `o_ImemAddr`=PC.
  - On `i_ImemAck`=1: latch `i_ImemRdata` into `o_Instruction`, latch PC into `o_Pc`, go to EXEC.
  - Otherwise stay in FETCH with the request and address held unchanged.
- EXEC:
  - `o_InstValid`=1 and `o_ImemReq`=0.
  - `i_Stall`=1: stay in EXEC, hold all outputs.
  - `i_Stall`=0 (the exit cycle): compute taken = `i_Jump` | (`i_Branch` & `i_Zero`).
  - Next PC = taken ? `i_Target` : PC+4.
  - If taken and `i_Target[1:0]`≠0: go to FAULT, leave PC unchanged, do not increment `o_RetireCnt`.
  - Otherwise: PC ← next PC, `o_RetireCnt` += 1, go to FETCH.
- FAULT: `o_Fault`=1, `o_ImemReq`=0, `o_InstValid`=0. The only exit is reset.
- Arithmetic:
  - PC+4 is modulo 2^ADDR_WIDTH, so FFFF_FFFC → 0000_0000.
  - `o_RetireCnt` wraps from FFFF_FFFF to 0.
  - `i_Target[1:0]` is checked only when taken; a not-taken branch ignores `i_Target`.
- `i_ImemAck` outside FETCH is ignored.
- `i_Branch`/`i_Jump`/`i_Zero`/`i_Target` outside the EXEC exit cycle are ignored.

## Timing
- Reset values:
  - `o_ImemReq`=0, `o_ImemAddr`=RESET_PC, `o_Pc`=RESET_PC.
  - `o_Instruction`=32'h0000_0013 (NOP), `o_InstValid`=0.
  - `o_Fault`=0, `o_RetireCnt`=0.
- Reset assertion takes effect immediately and asynchronously, including mid-FETCH with a request pending. The memory must tolerate an abandoned request.
- First request appears on cycle 2 after reset release: IDLE for 1 cycle, then FETCH.
- With zero-wait memory (ack in the first FETCH cycle) each instruction takes 2 cycles: FETCH, then EXEC. Each wait cycle adds 1.
- Data is captured on the ack edge; `o_InstValid` rises the following cycle.
- Redirect is registered: the new PC appears on `o_ImemAddr` in the FETCH cycle right after the EXEC exit.
- `o_Fault` rises the cycle after the faulting EXEC exit.

## Test plan
- Reset release, memory acks immediately with 0x00500093 → `o_ImemAddr`=0 on cycle 2; `o_InstValid` on cycle 3 with `o_Instruction`=0x00500093, `o_Pc`=0; next request at address 4; `o_RetireCnt`=1.
- Ack delayed 3 cycles at PC=8 → `o_ImemReq` held high with address 8 for 3 cycles; `o_InstValid` not asserted until the cycle after the ack.
- EXEC with `i_Branch`=1: `i_Zero`=1, `i_Target`=0x40 → next fetch at 0x40; repeat with `i_Zero`=0 → next fetch at PC+4.
- EXEC with `i_Jump`=1, `i_Target`=0x22 → `o_Fault`=1 next cycle; no further requests; `o_RetireCnt` unchanged; only `i_Rst_n` low clears the fault.
- `i_Stall`=1 for 4 cycles in EXEC → outputs frozen and `o_InstValid` held high; counter increments exactly once after the stall drops.
- PC=0xFFFF_FFFC, not taken → next fetch at 0; `i_Rst_n` pulsed low mid-FETCH → `o_ImemReq`=0 immediately and all outputs at their reset values.
